// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned A - B, LSB first; define SERIAL_SUB_OVERFLOW_EN for the signed overflow flag
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Difference_out,
    output logic             Borrow_out,
    output logic             Overflow_out
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sr, r_b_sr, r_res;
    logic             r_bq;
    logic             w_a, w_b, w_d1, w_b1, w_d, w_b2, w_bnext, w_last, w_accept;
    logic [WIDTH-1:0] w_res;
    assign w_a      = r_a_sr[0];
    assign w_b      = r_b_sr[0];
    assign w_d1     = w_a ^ w_b;
    assign w_b1     = ~w_a & w_b;
    assign w_d      = w_d1 ^ r_bq;
    assign w_b2     = ~w_d1 & r_bq;
    assign w_bnext  = w_b1 | w_b2;
    assign w_res    = {w_d, r_res[WIDTH-1:1]};
    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));
    assign busy     = (r_state == SHIFT);
    assign done     = (r_state == DONE);
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    // next state: IDLE -> SHIFT on start, SHIFT -> DONE after the last bit, DONE -> IDLE
    always_comb begin
        w_next = r_state;
        if (w_accept) w_next = SHIFT;
        else if (w_last) w_next = DONE;
        else if (r_state == DONE) w_next = IDLE;
    end
    // operand load, per-bit shift, and result capture on the last bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sr         <= '0;
            r_b_sr         <= '0;
            r_res          <= '0;
            r_bq           <= 1'b0;
            r_cnt          <= '0;
            Difference_out <= '0;
            Borrow_out     <= 1'b0;
        end else if (w_accept) begin
            r_a_sr <= A_in;
            r_b_sr <= B_in;
            r_bq   <= 1'b0;
            r_cnt  <= '0;
        end else if (r_state == SHIFT) begin
            r_a_sr <= r_a_sr >> 1;
            r_b_sr <= r_b_sr >> 1;
            r_res  <= w_res;
            r_bq   <= w_bnext;
            r_cnt  <= w_last ? r_cnt : r_cnt + CW'(1);
            if (w_last) begin
                Difference_out <= w_res;
                Borrow_out     <= w_bnext;
            end
        end
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    // signed overflow judged from the MSB step: operand signs differ and result sign differs from A
    always_ff @(posedge clk) begin
        if (!rst_n) Overflow_out <= 1'b0;
        else if (w_last) Overflow_out <= (w_a != w_b) && (w_d != w_a);
    end
`else
    assign Overflow_out = 1'b0;
`endif
endmodule
